// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store initiator for the 2-cycle-latency data_mem, driven
//               from the MEM pipeline stage. Accepts one request per
//               handshake, checks alignment and range, stalls the pipeline
//               across the load latency, returns the extended load data and
//               keeps saturating load/store event counters.
// Ports       : clock/reset_n      - clock, async active-low reset
//               req_*              - request handshake from the MEM stage
//               flush              - kill the in-flight load response
//               mem_*              - data_mem command / read data
//               stall              - freeze upstream pipeline
//               resp_valid/rdata   - load result
//               exc_valid/store/addr - misaligned / out-of-range fault report
//               cnt_loads/stores   - saturating completion counters
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_memwrite,
  output logic                  mem_memread,
  output logic [1:0]            mem_byte_size,
  output logic                  mem_sign_ext,
  input  logic [31:0]           mem_read_data,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  exc_valid,
  output logic                  exc_store,
  output logic [ADDR_WIDTH-1:0] exc_addr,
  output logic [CNT_WIDTH-1:0]  cnt_loads,
  output logic [CNT_WIDTH-1:0]  cnt_stores
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    FAULT = 2'd3
  } state_t;

  // One bit wider than the address so the end-of-access sum cannot wrap.
  localparam logic [ADDR_WIDTH:0] c_mem_limit = (ADDR_WIDTH+1)'(MEM_BYTES);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_kill;
  logic [ADDR_WIDTH-1:0]  r_exc_addr;
  logic                   r_exc_store;
  logic [CNT_WIDTH-1:0]   r_cnt_loads;
  logic [CNT_WIDTH-1:0]   r_cnt_stores;

  logic [2:0]             w_bytes;
  logic [ADDR_WIDTH:0]    w_end;
  logic                   w_bad;
  logic                   w_accept;
  logic                   w_killed;
  logic                   w_load_done;
  logic                   w_store_done;

  always_comb begin
    case (req_size)
      2'b00:   w_bytes = 3'd1;
      2'b01:   w_bytes = 3'd2;
      default: w_bytes = 3'd4;
    endcase
  end

  assign w_end = {1'b0, req_addr} + {{(ADDR_WIDTH-2){1'b0}}, w_bytes};

  assign w_bad = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (w_end > c_mem_limit);

  assign w_accept     = req_valid && (r_state == IDLE);
  // A flush seen during WAIT2 itself must also hide that cycle's response.
  assign w_killed     = r_kill || flush;
  assign w_load_done  = (r_state == WAIT2) && !w_killed;
  assign w_store_done = w_accept && req_write && !w_bad;

  // Next-state and output decode
  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_byte_size  = 2'b00;
    mem_sign_ext   = 1'b0;
    stall          = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    exc_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mem_address    = req_addr;
          mem_write_data = req_wdata;
          mem_byte_size  = req_size;
          mem_sign_ext   = req_signed;
          if (w_bad) begin
            stall  = 1'b1;
            w_next = FAULT;
          end else if (req_write) begin
            mem_memwrite = 1'b1;
          end else begin
            mem_memread = 1'b1;
            stall       = 1'b1;
            w_next      = WAIT1;
          end
        end
      end
      WAIT1: begin
        stall  = 1'b1;
        w_next = WAIT2;
      end
      WAIT2: begin
        resp_valid = !w_killed;
        resp_rdata = w_killed ? 32'd0 : mem_read_data;
        w_next     = IDLE;
      end
      FAULT: begin
        exc_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Kill flag lives only for the duration of one load; it clears on IDLE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_kill <= 1'b0;
    end else if (w_next == IDLE) begin
      r_kill <= 1'b0;
    end else if ((r_state == WAIT1 || r_state == WAIT2) && flush) begin
      r_kill <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exc_addr  <= '0;
      r_exc_store <= 1'b0;
    end else if (w_accept && w_bad) begin
      r_exc_addr  <= req_addr;
      r_exc_store <= req_write;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_loads  <= '0;
      r_cnt_stores <= '0;
    end else begin
      if (w_load_done && r_cnt_loads != {CNT_WIDTH{1'b1}}) begin
        r_cnt_loads <= r_cnt_loads + 1'b1;
      end
      if (w_store_done && r_cnt_stores != {CNT_WIDTH{1'b1}}) begin
        r_cnt_stores <= r_cnt_stores + 1'b1;
      end
    end
  end

  assign exc_addr   = r_exc_addr;
  assign exc_store  = r_exc_store;
  assign cnt_loads  = r_cnt_loads;
  assign cnt_stores = r_cnt_stores;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with a 2-cycle data_mem
//               model and an independent byte-array reference of memory,
//               faults and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int AW = 32;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write, req_signed, flush;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [1:0]    req_size;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          mem_memwrite, mem_memread, mem_sign_ext;
  logic [1:0]    mem_byte_size;
  logic [31:0]   mem_read_data = 32'd0;
  logic          stall, resp_valid, exc_valid, exc_store;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] exc_addr;
  logic [CW-1:0] cnt_loads, cnt_stores;

  lsu_ctrl #(.ADDR_WIDTH(AW), .MEM_BYTES(1024), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed), .flush(flush),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
    .mem_read_data(mem_read_data),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_store(exc_store), .exc_addr(exc_addr),
    .cnt_loads(cnt_loads), .cnt_stores(cnt_stores)
  );

  always #5 clock = ~clock;

  // ---------------- data_mem model: read data 2 edges after memread ---------
  logic [7:0]  dmem [0:1023];
  logic        rd_p = 1'b0;
  logic [9:0]  rd_a = '0;
  logic [1:0]  rd_sz = '0;
  logic        rd_sg = 1'b0;

  function automatic logic [31:0] mread(input logic [9:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{sg & dmem[a][7]}}, dmem[a]};
      2'b01:   v = {{16{sg & dmem[a+10'd1][7]}}, dmem[a+10'd1], dmem[a]};
      default: v = {dmem[a+10'd3], dmem[a+10'd2], dmem[a+10'd1], dmem[a]};
    endcase
    return v;
  endfunction

  always @(posedge clock) begin
    if (mem_memwrite) begin
      dmem[mem_address[9:0]] <= mem_write_data[7:0];
      if (mem_byte_size != 2'b00) dmem[mem_address[9:0]+10'd1] <= mem_write_data[15:8];
      if (mem_byte_size == 2'b10) begin
        dmem[mem_address[9:0]+10'd2] <= mem_write_data[23:16];
        dmem[mem_address[9:0]+10'd3] <= mem_write_data[31:24];
      end
    end
    rd_p  <= mem_memread;
    rd_a  <= mem_address[9:0];
    rd_sz <= mem_byte_size;
    rd_sg <= mem_sign_ext;
    if (rd_p) mem_read_data <= mread(rd_a, rd_sz, rd_sg);
  end

  // ---------------- reference model ------------------------------------------
  int unsigned ref_mem [0:1023];
  int          exp_ld, exp_st;
  logic [31:0] exp_exc_addr;
  logic        exp_exc_store;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    longint unsigned la = a;
    return (sz == 2'b11) || (la % nbytes(sz) != 0) || (la + nbytes(sz) > 1024);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_signed = 0; flush = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // One request from the MEM stage; the request is held while stalled.
  // Called and returns at 1 time unit after a rising edge.
  task automatic op(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                    input bit sg, input logic [31:0] wd, input bit fl);
    bit bad = is_bad(a, sz);
    req_valid = 1; req_write = wr; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd; flush = 0;
    #1;
    chk("accept_ready", req_ready, 1);
    chk("memread", mem_memread, !wr && !bad);
    chk("memwrite", mem_memwrite, wr && !bad);
    chk("stall_c0", stall, bad || !wr);
    chk("mem_address", mem_address, a);
    if (wr && !bad) chk("mem_wdata", mem_write_data, wd);
    @(posedge clock); #1;
    if (bad) begin
      exp_exc_addr = a; exp_exc_store = wr;
      chk("exc_valid", exc_valid, 1);
      chk("fault_stall", stall, 0);
      chk("fault_ready", req_ready, 0);
      @(posedge clock); #1;
      chk("exc_pulse_end", exc_valid, 0);
    end else if (wr) begin
      for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = (wd >> (8 * i)) & 32'hFF;
      if (exp_st < CMAX) exp_st++;
    end else begin
      flush = fl;
      #1;
      chk("wait1_stall", stall, 1);
      chk("wait1_memread", mem_memread, 0);
      chk("wait1_ready", req_ready, 0);
      @(posedge clock); #1;
      flush = 0;
      #1;
      chk("resp_valid", resp_valid, !fl);
      chk("wait2_stall", stall, 0);
      if (!fl) begin
        chk("resp_rdata", resp_rdata, ref_load(a, sz, sg));
        if (exp_ld < CMAX) exp_ld++;
      end
      @(posedge clock); #1;
    end
    chk("cnt_loads", cnt_loads, exp_ld);
    chk("cnt_stores", cnt_stores, exp_st);
    chk("exc_addr", exc_addr, exp_exc_addr);
    chk("exc_store", exc_store, exp_exc_store);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    exp_ld = 0; exp_st = 0; exp_exc_addr = 0; exp_exc_store = 0;
    reset_n = 0;
    idle(0);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_memrd", mem_memread, 0);
    chk("rst_memwr", mem_memwrite, 0);
    chk("rst_maddr", mem_address, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_exc_addr", exc_addr, 0);
    chk("rst_exc_store", exc_store, 0);
    chk("rst_cnt_ld", cnt_loads, 0);
    chk("rst_cnt_st", cnt_stores, 0);
    @(posedge clock); #1;
    reset_n = 1;
    idle(2);

    // directed cases
    op(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0);
    op(0, 32'h10, 2'b10, 0, 32'h0, 0);
    op(1, 32'h21, 2'b00, 0, 32'h80, 0);
    op(0, 32'h21, 2'b00, 1, 32'h0, 0);
    op(0, 32'h21, 2'b00, 0, 32'h0, 0);
    op(0, 32'h03, 2'b01, 0, 32'h0, 0);
    op(1, 32'h3FE, 2'b10, 0, 32'h12345678, 0);
    op(0, 32'h400, 2'b10, 0, 32'h0, 0);
    op(0, 32'h10, 2'b11, 0, 32'h0, 0);
    op(1, 32'h3FC, 2'b10, 0, 32'hA5C3_817E, 0);
    op(0, 32'h3FF, 2'b00, 1, 32'h0, 0);
    op(0, 32'h3FE, 2'b01, 1, 32'h0, 0);
    op(0, 32'h40, 2'b10, 0, 32'h0, 1);
    op(0, 32'h0, 2'b10, 0, 32'h0, 0);
    op(0, 32'h4, 2'b10, 0, 32'h0, 0);
    idle(1);

    // fill the regions the random phase reads; also drives cnt_stores to saturation
    for (int i = 0; i < 64; i++) op(1, i * 4, 2'b10, 0, $urandom, 0);
    for (int i = 0; i < 4; i++)  op(1, 32'h3F0 + i * 4, 2'b10, 0, $urandom, 0);

    for (int k = 0; k < 80; k++) begin
      bit wr = 1'($urandom_range(0, 1));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? 32'h3F0 + $urandom_range(0, 31)
                                                   : 32'($urandom_range(0, 255));
      bit fl = !wr && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~(nbytes(sz) - 1);
      op(wr, a, sz, 1'($urandom_range(0, 1)), $urandom, fl);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // reset during WAIT1
    op(1, 32'h80, 2'b10, 0, 32'hCAFEF00D, 0);
    req_valid = 1; req_write = 0; req_addr = 32'h80; req_size = 2'b10; req_signed = 0;
    @(posedge clock); #1;
    reset_n = 0;
    req_valid = 0;
    #1;
    exp_ld = 0; exp_st = 0; exp_exc_addr = 0; exp_exc_store = 0;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_stall", stall, 0);
    chk("midrst_resp", resp_valid, 0);
    chk("midrst_cnt_ld", cnt_loads, 0);
    chk("midrst_cnt_st", cnt_stores, 0);
    chk("midrst_exc_addr", exc_addr, 0);
    @(posedge clock); #1;
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("postrst_resp", resp_valid, 0);
      chk("postrst_ready", req_ready, 1);
      @(posedge clock); #1;
    end
    chk("postrst_cnt_ld", cnt_loads, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
